fir_filter_mc: RTL and testbench

Multi-channel, decimating, sequential-MAC FIR filter. It is the parametrised successor to the single-configuration filter. NR_CHANNELS independent DWIDTH-bit channels are packed in each data word and all channels share one coefficient set. Data moves over four-phase req/ack handshakes, with the filter as requester on both ports, between the sample source and sink.

---
 rtl/fir_filter_mc.sv | 156 +++++++++++++++
 tb/tb_fir_filter_mc.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_mc.sv
`default_nettype none
// ============================================================================
// Module      : fir_filter_mc
// Description : Multi-channel decimating FIR filter with one sequential MAC
//               per channel, four-phase req/ack on both input and output.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_filter_mc #(
    parameter int NR_STAGES   = 32,
    parameter int DWIDTH      = 16,
    parameter int NR_CHANNELS = 2,
    parameter int DDWIDTH     = NR_CHANNELS * DWIDTH,
    parameter int CWIDTH      = NR_STAGES * DWIDTH,
    parameter int DECIM       = 1,
    parameter int SHIFT       = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic               in_req,
    input  logic               in_ack,
    input  logic [0:DDWIDTH-1] in_data,
    output logic               out_req,
    input  logic               out_ack,
    output logic [0:DDWIDTH-1] out_data,
    input  logic [0:CWIDTH-1]  h_in
);

    localparam int c_acc_w = 2 * DWIDTH + $clog2(NR_STAGES);
    localparam int c_tap_w = (NR_STAGES > 1) ? $clog2(NR_STAGES) : 1;
    localparam int c_ph_w  = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [c_tap_w-1:0] c_tap_last = c_tap_w'(NR_STAGES - 1);
    localparam logic [c_ph_w-1:0]  c_ph_last  = c_ph_w'(DECIM - 1);

    localparam logic signed [c_acc_w-1:0] c_sat_max =
        {{(c_acc_w - DWIDTH + 1){1'b0}}, {(DWIDTH - 1){1'b1}}};
    localparam logic signed [c_acc_w-1:0] c_sat_min =
        {{(c_acc_w - DWIDTH + 1){1'b1}}, {(DWIDTH - 1){1'b0}}};

    localparam logic [2:0] c_st_req     = 3'd0;
    localparam logic [2:0] c_st_in_rel  = 3'd1;
    localparam logic [2:0] c_st_mac     = 3'd2;
    localparam logic [2:0] c_st_out     = 3'd3;
    localparam logic [2:0] c_st_out_rel = 3'd4;

    logic [2:0]               r_state;
    logic                     r_in_req;
    logic                     r_out_req;
    logic [0:DDWIDTH-1]       r_out_data;
    logic [c_tap_w-1:0]       r_tap;
    logic [c_ph_w-1:0]        r_phase;
    logic signed [DWIDTH-1:0] r_dline [NR_CHANNELS][NR_STAGES];
    logic signed [c_acc_w-1:0] r_acc  [NR_CHANNELS];

    logic signed [DWIDTH-1:0]   w_coef [NR_STAGES];
    logic signed [DWIDTH-1:0]   w_in   [NR_CHANNELS];
    logic signed [2*DWIDTH-1:0] w_prod [NR_CHANNELS];
    logic [0:DDWIDTH-1]         w_sat_word;

    assign in_req   = r_in_req;
    assign out_req  = r_out_req;
    assign out_data = r_out_data;

    for (genvar i = 0; i < NR_STAGES; i++) begin : g_coef
        assign w_coef[i] = h_in[i*DWIDTH +: DWIDTH];
    end

    for (genvar k = 0; k < NR_CHANNELS; k++) begin : g_ch
        logic signed [c_acc_w-1:0] w_shift;

        assign w_in[k]   = in_data[k*DWIDTH +: DWIDTH];
        assign w_prod[k] = (2*DWIDTH)'(r_dline[k][r_tap]) * (2*DWIDTH)'(w_coef[r_tap]);
        // Floor shift, then clamp into the signed sample range.
        assign w_shift   = r_acc[k] >>> SHIFT;
        assign w_sat_word[k*DWIDTH +: DWIDTH] =
            (w_shift > c_sat_max) ? c_sat_max[DWIDTH-1:0] :
            (w_shift < c_sat_min) ? c_sat_min[DWIDTH-1:0] :
                                    w_shift[DWIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_req;
            r_in_req   <= 1'b0;
            r_out_req  <= 1'b0;
            r_out_data <= '0;
            r_tap      <= '0;
            r_phase    <= '0;
            for (int k = 0; k < NR_CHANNELS; k++) begin
                r_acc[k] <= '0;
                for (int t = 0; t < NR_STAGES; t++) begin
                    r_dline[k][t] <= '0;
                end
            end
        end else begin
            case (r_state)
                c_st_req: begin
                    if (r_in_req && in_ack) begin
                        r_in_req <= 1'b0;
                        for (int k = 0; k < NR_CHANNELS; k++) begin
                            r_dline[k][0] <= w_in[k];
                            for (int t = NR_STAGES - 1; t > 0; t--) begin
                                r_dline[k][t] <= r_dline[k][t-1];
                            end
                        end
                        r_state <= c_st_in_rel;
                    end else begin
                        r_in_req <= 1'b1;
                    end
                end
                c_st_in_rel: begin
                    if (!in_ack) begin
                        if (r_phase == c_ph_last) begin
                            r_phase <= '0;
                            r_tap   <= '0;
                            for (int k = 0; k < NR_CHANNELS; k++) begin
                                r_acc[k] <= '0;
                            end
                            r_state <= c_st_mac;
                        end else begin
                            r_phase <= r_phase + c_ph_w'(1);
                            r_state <= c_st_req;
                        end
                    end
                end
                c_st_mac: begin
                    for (int k = 0; k < NR_CHANNELS; k++) begin
                        r_acc[k] <= r_acc[k] + c_acc_w'(w_prod[k]);
                    end
                    r_tap <= r_tap + c_tap_w'(1);
                    if (r_tap == c_tap_last) begin
                        r_state <= c_st_out;
                    end
                end
                c_st_out: begin
                    // First OUT cycle publishes the result; later cycles wait for ack.
                    if (!r_out_req) begin
                        r_out_req  <= 1'b1;
                        r_out_data <= w_sat_word;
                    end else if (out_ack) begin
                        r_out_req <= 1'b0;
                        r_state   <= c_st_out_rel;
                    end
                end
                c_st_out_rel: begin
                    if (!out_ack) begin
                        r_state <= c_st_req;
                    end
                end
                default: r_state <= c_st_req;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_filter_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_filter_mc
// Description : Randomised handshake bench for fir_filter_mc with a
//               convolution reference model and literal anchor values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_filter_mc;

    localparam int NST = 32;
    localparam int DW  = 16;
    localparam int NCH = 2;
    localparam int DDW = NCH * DW;
    localparam int CW  = NST * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst     [2];
    logic           in_req  [2];
    logic           in_ack  [2];
    logic [0:DDW-1] in_data [2];
    logic           out_req [2];
    logic           out_ack [2];
    logic [0:DDW-1] out_data[2];
    logic [0:CW-1]  h_in    [2];

    fir_filter_mc u_dut0 (
        .clk(clk), .rst(rst[0]),
        .in_req(in_req[0]), .in_ack(in_ack[0]), .in_data(in_data[0]),
        .out_req(out_req[0]), .out_ack(out_ack[0]), .out_data(out_data[0]),
        .h_in(h_in[0])
    );

    fir_filter_mc #(.DECIM(4), .SHIFT(14)) u_dut1 (
        .clk(clk), .rst(rst[1]),
        .in_req(in_req[1]), .in_ack(in_ack[1]), .in_data(in_data[1]),
        .out_req(out_req[1]), .out_ack(out_ack[1]), .out_data(out_data[1]),
        .h_in(h_in[1])
    );

    int shift_v [2];
    int decim_v [2];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int             hc      [2][NST];
    int             hist    [2][NCH][NST];
    int             phase   [2];
    bit             pending [2];
    bit             mac_wait[2];
    int             rel_edge[2];
    bit             prev_oreq[2];
    logic [0:DDW-1] held    [2];
    logic [0:DDW-1] exp_q   [2][$];
    logic [0:DDW-1] out_log [2][$];
    logic [0:DDW-1] in_log  [2][$];
    int             mode    [2];
    int             src_idx [2];
    int             src_lim [2];
    int             in_hold [2];
    int             out_dly [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int chan(input logic [0:DDW-1] w, input int c);
        logic signed [DW-1:0] s;
        s = w[c*DW +: DW];
        return int'(s);
    endfunction

    function automatic logic [0:DDW-1] pack2(input int a, input int b);
        logic [0:DDW-1] w;
        w[0 +: DW]  = a[DW-1:0];
        w[DW +: DW] = b[DW-1:0];
        return w;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // y[n] = sat(floor(sum_k h[k]*x[n-k] / 2^SHIFT)), per channel.
    function automatic logic [0:DDW-1] model_out(input int d);
        logic [0:DDW-1] w;
        longint acc;
        w = '0;
        for (int c = 0; c < NCH; c++) begin
            acc = 0;
            for (int k = 0; k < NST; k++) acc += longint'(hist[d][c][k]) * longint'(hc[d][k]);
            acc = acc >>> shift_v[d];
            if (acc > 32767) acc = 32767;
            else if (acc < -32768) acc = -32768;
            w[c*DW +: DW] = acc[DW-1:0];
        end
        return w;
    endfunction

    function automatic logic [0:DDW-1] gen_frame(input int d, input int idx);
        case (mode[d])
            0:       return pack2((idx == 0) ? 16384 : 0, 0);
            1:       return pack2(32767, -32768);
            2:       return pack2(1000, 1000);
            default: return pack2(rnd16(), rnd16());
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_port
        initial begin
            in_ack[g]  = 1'b0;
            in_data[g] = '0;
            forever begin
                @(posedge clk); #1;
                if (!rst[g] && in_req[g] && src_idx[g] < src_lim[g]) begin
                    if (mode[g] == 3) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    in_data[g] = gen_frame(g, src_idx[g]);
                    in_ack[g]  = 1'b1;
                    src_idx[g]++;
                    for (int t = 0; t < 200 && in_req[g]; t++) begin @(posedge clk); #1; end
                    repeat (in_hold[g]) begin @(posedge clk); #1; end
                    in_ack[g] = 1'b0;
                end
            end
        end

        initial begin
            out_ack[g] = 1'b0;
            forever begin
                @(posedge clk); #1;
                if (out_req[g]) begin
                    repeat (out_dly[g]) begin @(posedge clk); #1; end
                    out_ack[g] = 1'b1;
                    for (int t = 0; t < 200 && out_req[g]; t++) begin @(posedge clk); #1; end
                    out_ack[g] = 1'b0;
                end
            end
        end

        always @(negedge clk) begin
            logic [0:DDW-1] e;
            if (rst[g]) begin
                for (int c = 0; c < NCH; c++)
                    for (int k = 0; k < NST; k++) hist[g][c][k] = 0;
                exp_q[g].delete();
                pending[g]  = 1'b0;
                mac_wait[g] = 1'b0;
                phase[g]    = 0;
            end else begin
                check("req_exclusive", longint'(in_req[g] && out_req[g]), 0);
                if (pending[g] && in_ack[g]) check("in_req_low_until_ack_release", longint'(in_req[g]), 0);
                if (out_req[g] && prev_oreq[g]) check("out_data_stable", longint'(out_data[g] == held[g]), 1);
                if (out_req[g] && !prev_oreq[g]) begin
                    out_log[g].push_back(out_data[g]);
                    if (!mac_wait[g] || exp_q[g].size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        check("latency", cyc - rel_edge[g], NST + 1);
                        e = exp_q[g].pop_front();
                        for (int c = 0; c < NCH; c++) check("out_channel", chan(out_data[g], c), chan(e, c));
                    end
                    mac_wait[g] = 1'b0;
                end
                if (pending[g] && !in_ack[g]) begin
                    pending[g] = 1'b0;
                    if (phase[g] == decim_v[g] - 1) begin
                        phase[g] = 0;
                        exp_q[g].push_back(model_out(g));
                        rel_edge[g] = cyc + 1;
                        mac_wait[g] = 1'b1;
                    end else begin
                        phase[g]++;
                    end
                end else if (!pending[g] && in_req[g] && in_ack[g]) begin
                    for (int c = 0; c < NCH; c++) begin
                        for (int k = NST - 1; k > 0; k--) hist[g][c][k] = hist[g][c][k-1];
                        hist[g][c][0] = chan(in_data[g], c);
                    end
                    in_log[g].push_back(in_data[g]);
                    pending[g] = 1'b1;
                end
            end
            prev_oreq[g] = out_req[g];
            held[g]      = out_data[g];
        end
    end

    task automatic set_coefs(input int d, input int kind);
        int lp [22] = '{1024, 1024, 1280, 1792, 2304, 2816, 3072, 3584, 3840, 4096, 4352,
                        4352, 4096, 3840, 3584, 3072, 2816, 2304, 1792, 1280, 1024, 1024};
        int v;
        for (int k = 0; k < NST; k++) begin
            case (kind)
                0:       v = (k >= 5 && k <= 26) ? lp[k-5] : 0;
                1:       v = 32767;
                2:       v = (k == 0) ? 16384 : 0;
                default: v = rnd16();
            endcase
            hc[d][k] = v;
            h_in[d][k*DW +: DW] = v[DW-1:0];
        end
    endtask

    task automatic start_test(input int d, input int md, input int ck, input int n,
                              input int hold, input int dly);
        @(posedge clk); #1;
        rst[d]     = 1'b1;
        src_lim[d] = 0;
        repeat (2) begin @(posedge clk); #1; end
        set_coefs(d, ck);
        mode[d]    = md;
        src_idx[d] = 0;
        in_hold[d] = hold;
        out_dly[d] = dly;
        out_log[d].delete();
        in_log[d].delete();
        rst[d]     = 1'b0;
        src_lim[d] = n;
    endtask

    task automatic wait_outputs(input int d, input int n);
        for (int t = 0; t < 20000 && out_log[d].size() < n; t++) begin @(posedge clk); #1; end
        check("output_count", out_log[d].size(), n);
        repeat (80) begin @(posedge clk); #1; end
        check("no_extra_output", out_log[d].size(), n);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int idx_l [7] = '{5, 7, 13, 15, 26, 32, 40};
        int val_l [7] = '{256, 320, 960, 1088, 256, 0, 0};
        bit found;
        longint first;
        shift_v = '{16, 14};
        decim_v = '{1, 4};
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; src_lim[d] = 0; src_idx[d] = 0; mode[d] = 0;
            in_hold[d] = 0; out_dly[d] = 0; h_in[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;

        start_test(0, 0, 0, 41, 0, 0);
        wait_outputs(0, 41);
        for (int i = 0; i < 7; i++) check("impulse_ch0_literal", chan(out_log[0][idx_l[i]], 0), val_l[i]);
        check("impulse_ch1_zero", chan(out_log[0][13], 1), 0);

        start_test(0, 1, 1, 40, 0, 0);
        wait_outputs(0, 40);
        check("sat_first_ch0", chan(out_log[0][0], 0), 16383);
        check("sat_first_ch1_floor", chan(out_log[0][0], 1), -16384);
        check("sat_second_ch0", chan(out_log[0][1], 0), 32766);
        check("sat_second_ch1", chan(out_log[0][1], 1), -32767);
        check("sat_full_ch0", chan(out_log[0][39], 0), 32767);
        check("sat_full_ch1", chan(out_log[0][39], 1), -32768);

        start_test(1, 2, 2, 40, 0, 0);
        wait_outputs(1, 10);
        for (int i = 0; i < out_log[1].size(); i++) begin
            check("decim_ch0_literal", chan(out_log[1][i], 0), 1000);
            check("decim_ch1_literal", chan(out_log[1][i], 1), 1000);
        end

        start_test(0, 3, 3, 20, 5, 20);
        wait_outputs(0, 20);

        start_test(0, 3, 3, 200, 0, 0);
        for (int t = 0; t < 5000 && out_log[0].size() < 2; t++) begin @(posedge clk); #1; end
        found = 1'b0;
        for (int t = 0; t < 2000 && !found; t++) begin
            if (mac_wait[0] && cyc == rel_edge[0] + 9) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("mac_window_reached", longint'(found), 1);
        rst[0]     = 1'b1;
        src_lim[0] = 0;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        check("post_reset_in_req", longint'(in_req[0]), 0);
        check("post_reset_out_req", longint'(out_req[0]), 0);
        check("post_reset_out_data", longint'(out_data[0]), 0);
        out_log[0].delete();
        in_log[0].delete();
        src_lim[0] = src_idx[0] + 3;
        @(negedge clk);
        check("reset_then_in_req", longint'(in_req[0]), 1);
        #1;
        wait_outputs(0, 3);
        for (int c = 0; c < NCH; c++) begin
            first = (longint'(chan(in_log[0][0], c)) * longint'(hc[0][0])) >>> 16;
            check("first_after_reset", chan(out_log[0][0], c), first);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
